bus_dma_master: RTL and testbench
=================================

# bus_dma_master

Word-copy DMA engine that acts as a bus initiator on the same single-cycle addr/datain/dataout/we bus that the CPU drives into the IO/memory hub. On a start pulse it requests the bus from the arbiter, then alternates one read cycle and one write cycle per word. This lets memory and IO regions such as the SEG/LED PIO windows be filled or copied without CPU instructions. It sits beside the CPU, in front of the bus arbiter feeding the hub.

## Interface
- LEN_W, default 16: width of the word-count register; maximum transfer is 2^LEN_W-1 words.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- start  in  1  one-cycle request to begin a transfer; honoured only in IDLE.
- src  in  32  source byte address; bits [1:0] are ignored (treated as 0).
- dst  in  32  destination byte address; bits [1:0] are ignored (treated as 0).
- len  in  LEN_W  number of 32-bit words to copy.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transfer completes.
- bus_req  out  1  bus request to the arbiter.
- bus_gnt  in  1  bus grant from the arbiter; sampled each cycle.
- addr  out  32  bus address.
- dataout  out  32  bus write data.
- we  out  1  bus write enable.
- datain  in  32  bus read data; combinational response to addr within the same cycle.

## Operation
- States: IDLE, REQ, READ, WRITE, DONE.
- IDLE:
  - start=1 and len!=0: latch src/dst with [1:0] cleared into src_ptr/dst_ptr and len into remaining, then go to REQ.
  - start=1 and len=0: go directly to DONE; no bus request is made.
  - start in any other state is ignored. Latched values do not change.
- REQ: bus_req=1. Go to READ at the first edge where bus_gnt=1.
- READ: bus_req=1 and addr=src_ptr. If bus_gnt=1, capture datain into the word buffer at the edge and go to WRITE. If bus_gnt=0, hold state and do not capture.
- WRITE: bus_req=1, addr=dst_ptr, dataout=buffer, and we=bus_gnt.
  - If bus_gnt=1: at the edge, src_ptr+=4, dst_ptr+=4, remaining-=1. Go to DONE if remaining was 1, else go to READ.
  - If bus_gnt=0: hold state; we stays 0.
- DONE: done=1 and bus_req=0. Go to IDLE next edge.
- Ownership: addr, dataout and we are 0 whenever the block is not in READ/WRITE with bus_gnt=1, so the arbiter can OR-merge initiators.
- Pointer arithmetic is modulo 2^32. Incrementing past 32'hfffffffc wraps to 32'h00000000 with no error.
- No overlap check: with dst = src+4, each word is copied forward in order, which smears the first word.

## Timing
- Reset values: busy=0, done=0, bus_req=0, addr=0, dataout=0, we=0. State, pointers, remaining and buffer are all cleared.
- Reset takes priority over every other condition, including mid-transfer. The block returns to IDLE at that edge, bus_req drops the next cycle, and no partial write is issued after the reset edge.
- Latency with bus_gnt held high:
  - start is sampled at edge E0, REQ runs in the cycle after E0, READ begins after E1.
  - Each word takes 2 cycles (READ, WRITE).
  - done is high in the cycle after the last WRITE edge. Total: 2 + 2·len cycles from the start edge to the done cycle.
- len=0: done is high in the cycle after the start edge, and busy is high for that one cycle only.
- Grant loss mid-word: the state is frozen and exactly one read and one write are still performed per word. A word already captured in the buffer is never re-read.
- done and a new start in the same cycle: start is ignored because the block is not in IDLE. start is accepted from the first IDLE cycle.

## Test plan
- Basic copy: memory words 0x100..0x10c = 11,22,33,44; start with src=0x100, dst=0x200, len=4, gnt tied 1 -> 4 writes to 0x200..0x20c with data 11,22,33,44; done pulses 10 cycles after the start edge; busy is 0 afterwards.
- IO target: src=0x300 containing 0x00123456, dst=0xf0000000, len=1 -> one write with we=1, addr=0xf0000000, dataout=0x00123456; the SEG display shows 123456.
- Grant throttling: gnt low during REQ for 3 cycles and low for 2 cycles in the middle of a WRITE, len=2 -> we stays 0 while gnt is low; exactly 2 writes with correct data; done arrives 5 cycles later than in the ungated case.
- Edge cases: len=0 -> done the next cycle with bus_req never asserted; src=0xfffffffc, len=2 -> second read from addr 0x00000000; src=0x101 -> first read from 0x100.
- Reset mid-op: assert reset during the WRITE of word 2 of a len=4 transfer -> no write at that edge; all outputs 0 the next cycle; a subsequent start works normally.
- Start while busy: a second start with different src, issued during a transfer -> ignored; the original transfer completes unchanged.

Source files
------------

// File: rtl/bus_dma_master.sv
// Word-copy DMA initiator: after a start pulse it requests the shared
// addr/datain/dataout/we bus and moves len words from src to dst, one read
// cycle followed by one write cycle per word. Its bus outputs are zero
// whenever it does not own the bus, so the arbiter can OR-merge initiators.
`timescale 1ns/1ps
module bus_dma_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [31:0]      addr,
  output logic [31:0]      dataout,
  output logic             we,
  input  logic [31:0]      datain
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = '0;
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_t           state_q, state_d;
  logic [31:0]      src_ptr_q, dst_ptr_q, buf_q;
  logic [LEN_W-1:0] remaining_q;
  logic             busy_q, done_q, bus_req_q;
  logic             own;

  // Next-state decode; every bus-dependent move waits on bus_gnt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len != LEN_ZERO) ? REQ : DONE;
      REQ:     if (bus_gnt) state_d = READ;
      READ:    if (bus_gnt) state_d = WRITE;
      WRITE:   if (bus_gnt) state_d = (remaining_q == LEN_ONE) ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, registered status flags and transfer datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      buf_q       <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      bus_req_q <= (state_d == REQ) || (state_d == READ) || (state_d == WRITE);
      case (state_q)
        IDLE: begin
          // Zero-length requests skip the bus entirely and leave the
          // previously latched pointers untouched.
          if (start && (len != LEN_ZERO)) begin
            src_ptr_q   <= {src[31:2], 2'b00};
            dst_ptr_q   <= {dst[31:2], 2'b00};
            remaining_q <= len;
          end
        end
        READ: begin
          if (bus_gnt) buf_q <= datain;
        end
        WRITE: begin
          // Pointers wrap modulo 2^32 by plain overflow.
          if (bus_gnt) begin
            src_ptr_q   <= src_ptr_q + 32'd4;
            dst_ptr_q   <= dst_ptr_q + 32'd4;
            remaining_q <= remaining_q - LEN_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus drive only while granted; reset suppresses any write in its own cycle.
  always_comb begin
    own     = bus_gnt && !reset;
    addr    = 32'd0;
    dataout = 32'd0;
    we      = 1'b0;
    if (own && (state_q == READ)) begin
      addr = src_ptr_q;
    end else if (own && (state_q == WRITE)) begin
      addr    = dst_ptr_q;
      dataout = buf_q;
      we      = 1'b1;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bus_req = bus_req_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Testbench for bus_dma_master: word memory behind the bus, write log,
// and a reference model that derives expected writes and done timing.
`timescale 1ns/1ps
module tb_bus_dma_master;

  logic        clk = 1'b0;
  logic        reset, start, bus_gnt;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic        busy, done, bus_req, we;
  logic [31:0] addr, dataout, datain;

  always #5 clk = ~clk;

  bus_dma_master #(.LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .addr(addr), .dataout(dataout), .we(we), .datain(datain)
  );

  // 1024-word memory decoded on addr[11:2]; reads are combinational.
  logic [31:0] mem [0:1023];
  assign datain = mem[addr[11:2]];

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int req_cnt  = 0;
  int own_viol = 0;

  // Bus monitor: log every write edge, count request cycles, watch ownership.
  always @(posedge clk) begin
    if (we) begin
      wq_addr.push_back(addr);
      wq_data.push_back(dataout);
    end
    if (bus_req) req_cnt <= req_cnt + 1;
    if (!bus_gnt && (we || addr != 32'd0 || dataout != 32'd0)) own_viol <= own_viol + 1;
  end

  int checks = 0;
  int errors = 0;
  int applied = 0;
  int wbase = 0;
  logic [31:0] ea[$];
  logic [31:0] ed[$];

  // Commit logged bus writes into the memory array.
  task automatic apply_writes();
    logic [31:0] a;
    while (applied < wq_addr.size()) begin
      a = wq_addr[applied];
      mem[a[11:2]] = wq_data[applied];
      applied++;
    end
  endtask

  // Reference model: sequential word copy on a snapshot of memory; done is
  // expected one cycle after the (2n+1)-th granted edge (1 REQ + 2 per word).
  task automatic do_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                         input int gmode, input int inj_cyc, input logic [31:0] inj_src,
                         output int done_cyc, output int exp_cyc);
    logic [31:0] refm [0:1023];
    logic [31:0] sa, da, v;
    logic        g;
    int          ng;
    apply_writes();
    refm = mem;
    ea.delete();
    ed.delete();
    for (int i = 0; i < n; i++) begin
      sa = {s[31:2], 2'b00} + 32'(4 * i);
      da = {d[31:2], 2'b00} + 32'(4 * i);
      v  = refm[sa[11:2]];
      ea.push_back(da);
      ed.push_back(v);
      refm[da[11:2]] = v;
    end
    wbase = wq_addr.size();
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = 16'(n); bus_gnt = 1'b1;
    ng = 0;
    exp_cyc  = (n == 0) ? 1 : -1;
    done_cyc = -1;
    for (int k = 1; k <= 400 && done_cyc < 0; k++) begin
      @(negedge clk);
      apply_writes();
      start = (k == inj_cyc);
      if (k == inj_cyc) src = inj_src;
      if (done === 1'b1) done_cyc = k;
      case (gmode)
        1:       g = ($urandom_range(0, 3) != 0);
        2:       g = !(k inside {1, 2, 3, 6, 7});
        default: g = 1'b1;
      endcase
      bus_gnt = g;
      if (n != 0 && g && exp_cyc < 0) begin
        ng++;
        if (ng == 2 * n + 1) exp_cyc = k + 1;
      end
    end
    start = 1'b0;
    bus_gnt = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bus_gnt = 1'b0; src = '0; dst = '0; len = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (bus_req !== 1'b0)  begin errors++; $display("FAIL reset_req got %b want 0", bus_req); end
    checks++; if (addr !== 32'd0)    begin errors++; $display("FAIL reset_addr got %h want 0", addr); end
    checks++; if (dataout !== 32'd0) begin errors++; $display("FAIL reset_dout got %h want 0", dataout); end
    checks++; if (we !== 1'b0)       begin errors++; $display("FAIL reset_we got %b want 0", we); end
    reset = 1'b0;
    bus_gnt = 1'b1;
  endtask

  task automatic test_basic();
    int dc, ec, nw;
    mem[32'h100 >> 2] = 32'h11; mem[32'h104 >> 2] = 32'h22;
    mem[32'h108 >> 2] = 32'h33; mem[32'h10c >> 2] = 32'h44;
    do_xfer(32'h100, 32'h200, 4, 0, -1, 32'd0, dc, ec);
    checks++; if (dc != 10) begin errors++; $display("FAIL basic_done_cyc got %0d want 10", dc); end
    nw = wq_addr.size() - wbase;
    checks++; if (nw != 4) begin errors++; $display("FAIL basic_nwr got %0d want 4", nw); end
    for (int i = 0; i < nw && i < 4; i++) begin
      checks++;
      if (wq_addr[wbase+i] !== 32'h200 + 32'(4*i) || wq_data[wbase+i] !== 32'(17 * (i + 1))) begin
        errors++;
        $display("FAIL basic_wr%0d got %h/%h want %h/%h", i, wq_addr[wbase+i], wq_data[wbase+i],
                 32'h200 + 32'(4*i), 32'(17 * (i + 1)));
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_io();
    int dc, ec, nw;
    mem[32'h300 >> 2] = 32'h00123456;
    do_xfer(32'h300, 32'hf0000000, 1, 0, -1, 32'd0, dc, ec);
    nw = wq_addr.size() - wbase;
    checks++; if (nw != 1) begin errors++; $display("FAIL io_nwr got %0d want 1", nw); end
    if (nw >= 1) begin
      checks++;
      if (wq_addr[wbase] !== 32'hf0000000 || wq_data[wbase] !== 32'h00123456) begin
        errors++; $display("FAIL io_wr got %h/%h want f0000000/00123456", wq_addr[wbase], wq_data[wbase]);
      end
    end
    checks++; if (dc != 4) begin errors++; $display("FAIL io_done_cyc got %0d want 4", dc); end
  endtask

  task automatic test_throttle();
    int dc, ec, nw, ov;
    ov = own_viol;
    mem[32'h140 >> 2] = $urandom; mem[32'h144 >> 2] = $urandom;
    do_xfer(32'h140, 32'h240, 2, 2, -1, 32'd0, dc, ec);
    checks++; if (dc != 11 || ec != 11) begin errors++; $display("FAIL thr_done_cyc got %0d want 11 (model %0d)", dc, ec); end
    nw = wq_addr.size() - wbase;
    checks++; if (nw != 2) begin errors++; $display("FAIL thr_nwr got %0d want 2", nw); end
    for (int i = 0; i < nw && i < ea.size(); i++) begin
      checks++;
      if (wq_addr[wbase+i] !== ea[i] || wq_data[wbase+i] !== ed[i]) begin
        errors++; $display("FAIL thr_wr%0d got %h/%h want %h/%h", i, wq_addr[wbase+i], wq_data[wbase+i], ea[i], ed[i]);
      end
    end
    checks++; if (own_viol != ov) begin errors++; $display("FAIL thr_ownership got %0d want %0d", own_viol, ov); end
  endtask

  task automatic test_edges();
    int dc, ec, nw, rq;
    logic [31:0] va, vb, vc;
    rq = req_cnt;
    do_xfer(32'h100, 32'h200, 0, 0, -1, 32'd0, dc, ec);
    checks++; if (dc != 1) begin errors++; $display("FAIL len0_done_cyc got %0d want 1", dc); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL len0_busy got %b want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy_after got %b want 0", busy); end
    checks++; if (req_cnt != rq || wq_addr.size() != wbase) begin
      errors++; $display("FAIL len0_no_bus got req %0d wr %0d want 0 0", req_cnt - rq, wq_addr.size() - wbase);
    end
    va = $urandom; vb = $urandom;
    mem[1023] = va; mem[0] = vb;
    do_xfer(32'hfffffffc, 32'h400, 2, 0, -1, 32'd0, dc, ec);
    nw = wq_addr.size() - wbase;
    checks++;
    if (nw != 2 || wq_data[wbase] !== va || wq_data[wbase+1] !== vb || wq_addr[wbase+1] !== 32'h404) begin
      errors++; $display("FAIL wrap_src got n=%0d want data %h,%h", nw, va, vb);
    end
    vc = $urandom;
    mem[32'h100 >> 2] = vc;
    do_xfer(32'h101, 32'h503, 1, 0, -1, 32'd0, dc, ec);
    nw = wq_addr.size() - wbase;
    checks++;
    if (nw != 1 || wq_addr[wbase] !== 32'h500 || wq_data[wbase] !== vc) begin
      errors++; $display("FAIL unaligned got n=%0d want 1 write %h to 00000500", nw, vc);
    end
  endtask

  task automatic test_reset_mid();
    int base, nw, dc, ec;
    logic [31:0] v0;
    apply_writes();
    for (int i = 0; i < 4; i++) mem[(32'h600 >> 2) + i] = $urandom;
    v0 = mem[32'h600 >> 2];
    base = wq_addr.size();
    @(negedge clk);
    start = 1'b1; src = 32'h600; dst = 32'h700; len = 16'd4; bus_gnt = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      apply_writes();
      start = 1'b0;
      if (k == 5) reset = 1'b1;
    end
    @(negedge clk);
    apply_writes();
    reset = 1'b0;
    nw = wq_addr.size() - base;
    checks++; if (nw != 1) begin errors++; $display("FAIL rstmid_nwr got %0d want 1", nw); end
    checks++; if (nw >= 1 && wq_data[base] !== v0) begin errors++; $display("FAIL rstmid_wr0 got %h want %h", wq_data[base], v0); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus_req !== 1'b0 || addr !== 32'd0 || dataout !== 32'd0 || we !== 1'b0) begin
      errors++; $display("FAIL rstmid_outs got busy%b done%b req%b addr%h dout%h we%b want all 0",
                         busy, done, bus_req, addr, dataout, we);
    end
    do_xfer(32'h600, 32'h780, 4, 0, -1, 32'd0, dc, ec);
    nw = wq_addr.size() - wbase;
    checks++; if (nw != 4 || dc != 10) begin errors++; $display("FAIL rstmid_restart got n=%0d cyc=%0d want 4 10", nw, dc); end
    for (int i = 0; i < nw && i < ea.size(); i++) begin
      checks++;
      if (wq_addr[wbase+i] !== ea[i] || wq_data[wbase+i] !== ed[i]) begin
        errors++; $display("FAIL rstmid_wr%0d got %h/%h want %h/%h", i, wq_addr[wbase+i], wq_data[wbase+i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_start_busy();
    int dc, ec, nw;
    for (int i = 0; i < 3; i++) begin
      mem[(32'h800 >> 2) + i] = $urandom;
      mem[(32'h900 >> 2) + i] = $urandom;
    end
    do_xfer(32'h800, 32'ha00, 3, 0, 3, 32'h900, dc, ec);
    checks++; if (dc != 8) begin errors++; $display("FAIL sbusy_done_cyc got %0d want 8", dc); end
    nw = wq_addr.size() - wbase;
    checks++; if (nw != 3) begin errors++; $display("FAIL sbusy_nwr got %0d want 3", nw); end
    for (int i = 0; i < nw && i < ea.size(); i++) begin
      checks++;
      if (wq_addr[wbase+i] !== ea[i] || wq_data[wbase+i] !== ed[i]) begin
        errors++; $display("FAIL sbusy_wr%0d got %h/%h want %h/%h", i, wq_addr[wbase+i], wq_data[wbase+i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_random();
    int dc, ec, nw, n;
    logic [31:0] s, d;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) mem[$urandom_range(0, 1023)] = $urandom;
      s = 32'($urandom_range(0, 32'hfff));
      d = 32'($urandom_range(0, 32'hfff));
      n = $urandom_range(1, 8);
      do_xfer(s, d, n, 1, -1, 32'd0, dc, ec);
      checks++; if (dc != ec) begin errors++; $display("FAIL rnd%0d_done_cyc got %0d want %0d", t, dc, ec); end
      nw = wq_addr.size() - wbase;
      checks++; if (nw != n) begin errors++; $display("FAIL rnd%0d_nwr got %0d want %0d", t, nw, n); end
      for (int i = 0; i < nw && i < ea.size(); i++) begin
        checks++;
        if (wq_addr[wbase+i] !== ea[i] || wq_data[wbase+i] !== ed[i]) begin
          errors++; $display("FAIL rnd%0d_wr%0d got %h/%h want %h/%h", t, i, wq_addr[wbase+i], wq_data[wbase+i], ea[i], ed[i]);
        end
      end
    end
    checks++; if (own_viol != 0) begin errors++; $display("FAIL ownership got %0d violations want 0", own_viol); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) ^ 32'h5a5a0000;
    test_reset();
    test_basic();
    test_io();
    test_throttle();
    test_edges();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
